reflex_round_ctrl: RTL and testbench

- Consumer end of the ball-target interface: requests new targets via a one-cycle new_ball pulse, latches ballX/ballY, then waits for a player click.
- Decides hit (cursor inside the 40x40 target) or miss (timeout) and measures reaction time in milliseconds.
- Tracks score and best time over a fixed number of rounds.
- Sits between the ball generator, the cursor/click input logic and the VGA/score display.

---
 rtl/reflex_pkg.sv | 18 +
 rtl/ms_tick_gen.sv | 29 ++
 rtl/reflex_round_ctrl.sv | 168 ++++++++++++++++
 tb/tb_reflex_round_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reflex_pkg.sv
// Shared types and constants for the reflex-game round controller.
package reflex_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_SETTLE = 3'd2,
    S_WAIT   = 3'd3,
    S_NEXT   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam int BALL_SIZE = 40;
  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int MS_W      = 12;

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running clock divider producing a one-cycle tick every TICK_DIV enabled cycles.
module ms_tick_gen #(
  parameter int TICK_DIV = 25000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] div_reg;
  logic          wrap;

  assign wrap = (div_reg == CW'(TICK_DIV - 1));
  assign tick = en && wrap;

  // clr wins over en so a new round always starts from a full millisecond.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      div_reg <= '0;
    end else if (en) begin
      div_reg <= wrap ? '0 : div_reg + CW'(1);
    end
  end

endmodule

// File: rtl/reflex_round_ctrl.sv
// Round controller for the reflex game: requests targets, judges hit/miss, tracks score.
// Optional macro REFLEX_CLICK_PENALTY_EN turns an out-of-box click into an immediate miss.
module reflex_round_ctrl #(
  parameter int TICK_DIV   = 25000,
  parameter int TIMEOUT_MS = 2000,
  parameter int ROUNDS     = 10,
  parameter int BALL_SIZE  = reflex_pkg::BALL_SIZE,
  parameter int SETTLE     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        click,
  input  logic [9:0]  cursorX,
  input  logic [9:0]  cursorY,
  input  logic [9:0]  ballX,
  input  logic [9:0]  ballY,
  output logic        new_ball,
  output logic [9:0]  tgtX,
  output logic [9:0]  tgtY,
  output logic        ball_visible,
  output logic        hit,
  output logic        miss,
  output logic [11:0] react_ms,
  output logic [11:0] best_ms,
  output logic [4:0]  score,
  output logic        done
);

  import reflex_pkg::*;

  state_t          state_reg, state_next;
  logic [7:0]      settle_cnt_reg;
  logic [MS_W-1:0] ms_cnt_reg;
  logic [4:0]      round_reg;
  logic [9:0]      tgt_x_reg, tgt_y_reg;
  logic            hit_reg, miss_reg, done_reg;
  logic [MS_W-1:0] react_reg, best_reg;
  logic [4:0]      score_reg;

  logic            tick;
  logic            settle_last;
  logic            in_box;
  logic            timed_out;
  logic            hit_cond, miss_cond;
  logic            round_last;
  logic            game_start;
  logic [10:0]     cx_ext, cy_ext, bx_ext, by_ext;

  ms_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (settle_last),
    .en  (state_reg == S_WAIT),
    .tick(tick)
  );

  // Box bounds are computed one bit wider so tgt+BALL_SIZE never wraps.
  always_comb begin
    cx_ext = {1'b0, cursorX};
    cy_ext = {1'b0, cursorY};
    bx_ext = {1'b0, tgt_x_reg};
    by_ext = {1'b0, tgt_y_reg};
    in_box = (cx_ext >= bx_ext) && (cx_ext < bx_ext + 11'(BALL_SIZE)) &&
             (cy_ext >= by_ext) && (cy_ext < by_ext + 11'(BALL_SIZE));
  end

  always_comb begin
    settle_last = (state_reg == S_SETTLE) && (settle_cnt_reg == 8'(SETTLE - 1));
    timed_out   = (ms_cnt_reg >= MS_W'(TIMEOUT_MS));
    hit_cond    = (state_reg == S_WAIT) && click && in_box;
`ifdef REFLEX_CLICK_PENALTY_EN
    miss_cond   = (state_reg == S_WAIT) && !hit_cond && (timed_out || click);
`else
    miss_cond   = (state_reg == S_WAIT) && !hit_cond && timed_out;
`endif
    round_last  = ((round_reg + 5'd1) == 5'(ROUNDS));
    game_start  = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (game_start) state_next = S_REQ;
      S_REQ:    state_next = S_SETTLE;
      S_SETTLE: if (settle_last) state_next = S_WAIT;
      S_WAIT:   if (hit_cond || miss_cond) state_next = S_NEXT;
      S_NEXT:   state_next = round_last ? S_DONE : S_REQ;
      S_DONE:   if (game_start) state_next = S_REQ;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt_reg <= '0;
      ms_cnt_reg     <= '0;
      round_reg      <= '0;
      tgt_x_reg      <= '0;
      tgt_y_reg      <= '0;
      hit_reg        <= 1'b0;
      miss_reg       <= 1'b0;
      done_reg       <= 1'b0;
      react_reg      <= '0;
      best_reg       <= '1;
      score_reg      <= '0;
    end else begin
      hit_reg  <= hit_cond;
      miss_reg <= miss_cond;

      if (game_start) begin
        score_reg <= '0;
        done_reg  <= 1'b0;
        round_reg <= '0;
        best_reg  <= '1;
      end

      if (state_reg == S_SETTLE) begin
        settle_cnt_reg <= settle_last ? 8'd0 : settle_cnt_reg + 8'd1;
      end

      if (settle_last) begin
        tgt_x_reg  <= ballX;
        tgt_y_reg  <= ballY;
        ms_cnt_reg <= '0;
      end else if ((state_reg == S_WAIT) && tick) begin
        ms_cnt_reg <= ms_cnt_reg + MS_W'(1);
      end

      if (hit_cond) begin
        react_reg <= ms_cnt_reg;
        score_reg <= score_reg + 5'd1;
        if (ms_cnt_reg < best_reg) begin
          best_reg <= ms_cnt_reg;
        end
      end

      if (state_reg == S_NEXT) begin
        round_reg <= round_reg + 5'd1;
        if (round_last) begin
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign new_ball     = (state_reg == S_REQ);
  assign ball_visible = (state_reg == S_WAIT);
  assign tgtX         = tgt_x_reg;
  assign tgtY         = tgt_y_reg;
  assign hit          = hit_reg;
  assign miss         = miss_reg;
  assign react_ms     = react_reg;
  assign best_ms      = best_reg;
  assign score        = score_reg;
  assign done         = done_reg;

endmodule

// File: tb/tb_reflex_round_ctrl.sv
// Randomised self-checking bench for reflex_round_ctrl against a game-level reference model.
module tb_reflex_round_ctrl;

  localparam int TICK_DIV   = 4;
  localparam int TIMEOUT_MS = 10;
  localparam int ROUNDS     = 3;
  localparam int SETTLE     = 2;
  localparam int BOX        = 40;

`ifdef REFLEX_CLICK_PENALTY_EN
  localparam bit PENALTY = 1'b1;
`else
  localparam bit PENALTY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        click = 1'b0;
  logic [9:0]  cursorX = '0, cursorY = '0, ballX = '0, ballY = '0;
  logic        new_ball, ball_visible, hit, miss, done;
  logic [9:0]  tgtX, tgtY;
  logic [11:0] react_ms, best_ms;
  logic [4:0]  score;

  int n_checks = 0;
  int n_pass   = 0;

  // game-level model state
  int m_score, m_best, m_react, m_rounds;
  bit m_done;

  reflex_round_ctrl #(
    .TICK_DIV(TICK_DIV), .TIMEOUT_MS(TIMEOUT_MS), .ROUNDS(ROUNDS),
    .BALL_SIZE(BOX), .SETTLE(SETTLE)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .click(click),
    .cursorX(cursorX), .cursorY(cursorY), .ballX(ballX), .ballY(ballY),
    .new_ball(new_ball), .tgtX(tgtX), .tgtY(tgtY), .ball_visible(ball_visible),
    .hit(hit), .miss(miss), .react_ms(react_ms), .best_ms(best_ms),
    .score(score), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_score = 0; m_best = 4095; m_react = 0; m_rounds = 0; m_done = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    model_reset();
    n_checks++;
    if ({new_ball, ball_visible, hit, miss, done} !== 5'b0)
      $display("FAIL reset_flags got=%b want=00000", {new_ball, ball_visible, hit, miss, done});
    else n_pass++;
    n_checks++;
    if (tgtX !== 10'd0 || tgtY !== 10'd0 || react_ms !== 12'd0 || score !== 5'd0)
      $display("FAIL reset_values got tgt=%0d,%0d react=%0d score=%0d want all 0", tgtX, tgtY, react_ms, score);
    else n_pass++;
    n_checks++;
    if (best_ms !== 12'hFFF) $display("FAIL reset_best got=%h want=fff", best_ms);
    else n_pass++;
  endtask

  // Leaves the bench sampling the REQ cycle (new_ball high).
  task automatic start_game(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    m_score = 0; m_best = 4095; m_rounds = 0; m_done = 0;
    n_checks++;
    if (new_ball !== 1'b1) $display("FAIL %s start_latency new_ball got=%b want=1", tag, new_ball);
    else n_pass++;
    n_checks++;
    if (score !== 5'(m_score) || best_ms !== 12'(m_best) || done !== m_done)
      $display("FAIL %s start_clear got score=%0d best=%0d done=%b want score=0 best=4095 done=0",
               tag, score, best_ms, done);
    else n_pass++;
  endtask

  // Plays one round from the REQ cycle; cw is the WAIT cycle index of the click (-1: none).
  task automatic play_round(input int bx, input int by, input int cx, input int cy,
                            input int cw, input string tag);
    int  t_out, exp_w, got_w, exp_ms;
    bit  exp_hit, inb, got_hit, got_miss, both;
    ballX = 10'(bx); ballY = 10'(by);
    step();
    n_checks++;
    if (new_ball !== 1'b0) $display("FAIL %s new_ball_width got=%b want=0", tag, new_ball);
    else n_pass++;
    for (int i = 1; i < SETTLE; i++) step();
    n_checks++;
    if (ball_visible !== 1'b0) $display("FAIL %s early_visible got=%b want=0", tag, ball_visible);
    else n_pass++;
    step();
    n_checks++;
    if (ball_visible !== 1'b1 || tgtX !== 10'(bx) || tgtY !== 10'(by))
      $display("FAIL %s target got vis=%b tgt=%0d,%0d want vis=1 tgt=%0d,%0d",
               tag, ball_visible, tgtX, tgtY, bx, by);
    else n_pass++;

    // reference: outcome from game rules in milliseconds
    t_out = TIMEOUT_MS * TICK_DIV;
    inb = (cx >= bx) && (cx < bx + BOX) && (cy >= by) && (cy < by + BOX);
    exp_hit = 1'b0; exp_w = t_out; exp_ms = 0;
    if (cw >= 0 && cw <= t_out) begin
      if (inb) begin
        exp_hit = 1'b1; exp_w = cw; exp_ms = cw / TICK_DIV;
      end else if (PENALTY) begin
        exp_w = cw;
      end
    end

    cursorX = 10'(cx); cursorY = 10'(cy);
    got_w = -1; got_hit = 0; got_miss = 0; both = 0;
    for (int w = 0; w < t_out + 20; w++) begin
      click = (w == cw);
      step();
      click = 1'b0;
      if (hit && miss) both = 1;
      if (hit || miss) begin
        got_w = w; got_hit = hit; got_miss = miss;
        break;
      end
    end
    n_checks++;
    if (both) $display("FAIL %s hit_and_miss got both=1 want 0", tag);
    else n_pass++;
    n_checks++;
    if (got_w !== exp_w || got_hit !== exp_hit || got_miss !== !exp_hit)
      $display("FAIL %s outcome got hit=%b miss=%b at_cycle=%0d want hit=%b miss=%b at_cycle=%0d",
               tag, got_hit, got_miss, got_w, exp_hit, !exp_hit, exp_w);
    else n_pass++;

    if (exp_hit) begin
      m_score++; m_react = exp_ms;
      if (exp_ms < m_best) m_best = exp_ms;
    end
    m_rounds++;
    if (m_rounds == ROUNDS) m_done = 1;
    n_checks++;
    if (react_ms !== 12'(m_react) || score !== 5'(m_score) || best_ms !== 12'(m_best))
      $display("FAIL %s stats got react=%0d score=%0d best=%0d want react=%0d score=%0d best=%0d",
               tag, react_ms, score, best_ms, m_react, m_score, m_best);
    else n_pass++;

    step();
    n_checks++;
    if (hit !== 1'b0 || miss !== 1'b0 || ball_visible !== 1'b0 ||
        new_ball !== !m_done || done !== m_done)
      $display("FAIL %s after_round got hit=%b miss=%b vis=%b new_ball=%b done=%b want 0 0 0 %b %b",
               tag, hit, miss, ball_visible, new_ball, done, !m_done, m_done);
    else n_pass++;
    $display("round %s ball=(%0d,%0d) cur=(%0d,%0d) click_cyc=%0d -> hit=%b react=%0d score=%0d best=%0d",
             tag, bx, by, cx, cy, cw, got_hit, react_ms, score, best_ms);
  endtask

  task automatic test_directed_game();
    start_game("g1");
    play_round(100, 200, 139, 239, 5 * TICK_DIV, "g1_hit5");
    play_round(100, 200, 140, 239, 2 * TICK_DIV, "g1_edge");
    play_round(300, 50, 310, 60, 3 * TICK_DIV, "g1_hit3");
  endtask

  task automatic test_timeout_boundary();
    start_game("g2");
    play_round(20, 30, 59, 69, TIMEOUT_MS * TICK_DIV, "g2_hit_at_timeout");
    play_round(20, 30, 19, 40, 1, "g2_left_edge");
    play_round(600, 440, 639, 479, -1, "g2_no_click");
  endtask

  task automatic test_random_games();
    int bx, by, cx, cy, cw;
    for (int g = 0; g < 4; g++) begin
      start_game("rnd");
      for (int r = 0; r < ROUNDS; r++) begin
        bx = $urandom_range(0, 600);
        by = $urandom_range(0, 440);
        if ($urandom_range(0, 9) < 6) begin
          cx = bx + $urandom_range(0, BOX - 1);
          cy = by + $urandom_range(0, BOX - 1);
        end else begin
          cx = bx + BOX + $urandom_range(0, 3);
          cy = by + $urandom_range(0, BOX + 3);
        end
        cw = $urandom_range(0, TIMEOUT_MS * TICK_DIV + 5);
        play_round(bx, by, cx, cy, cw, "rnd");
      end
    end
  endtask

  task automatic test_reset_mid();
    bit stray;
    start_game("g3");
    play_round(200, 100, 210, 110, 6, "g3_hit");
    ballX = 10'd200; ballY = 10'd100;
    repeat (SETTLE + 1) step();
    n_checks++;
    if (ball_visible !== 1'b1 || score !== 5'd1)
      $display("FAIL mid_precond got vis=%b score=%0d want vis=1 score=1", ball_visible, score);
    else n_pass++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    n_checks++;
    if ({new_ball, ball_visible, hit, miss, done} !== 5'b0 || score !== 5'd0 ||
        react_ms !== 12'd0 || best_ms !== 12'hFFF || tgtX !== 10'd0 || tgtY !== 10'd0)
      $display("FAIL mid_reset got flags=%b score=%0d react=%0d best=%0d tgt=%0d,%0d want 0s and best=4095",
               {new_ball, ball_visible, hit, miss, done}, score, react_ms, best_ms, tgtX, tgtY);
    else n_pass++;
    cursorX = 10'd5; cursorY = 10'd5;
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      click = 1'b1;
      step();
      if (hit || miss || new_ball || ball_visible || score != 5'd0) stray = 1;
    end
    click = 1'b0;
    n_checks++;
    if (stray) $display("FAIL idle_click got activity=1 want 0");
    else n_pass++;
    $display("reset_mid: aborted game, idle clicks ignored=%b", !stray);
  endtask

  initial begin
    test_reset();
    test_directed_game();
    test_timeout_boundary();
    test_random_games();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
